dds_cmd_parser: RTL and testbench

Byte-stream command decoder between the Ethernet UDP receive path and the DDS drive stage. It frames, checksums and range-checks configuration commands, then drives the DDS control inputs (`run`, `fword`, `pword`, `mode`, `duty`). Each output is a held value plus a one-cycle valid strobe. Malformed, stalled or out-of-range frames are dropped and flagged; they never disturb the held values.

---
 rtl/dds_cmd_pkg.sv | 55 +++++
 rtl/dds_cmd_timeout.sv | 31 +++
 rtl/dds_cmd_parser.sv | 146 ++++++++++++++
 tb/tb_dds_cmd_parser.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_cmd_pkg.sv
// Shared constants, FSM encoding and command-table helpers for the DDS command parser.
package dds_cmd_pkg;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hAA;

  localparam logic [7:0] CMD_RUN   = 8'h01;
  localparam logic [7:0] CMD_FWORD = 8'h02;
  localparam logic [7:0] CMD_PWORD = 8'h03;
  localparam logic [7:0] CMD_MODE  = 8'h04;
  localparam logic [7:0] CMD_DUTY  = 8'h05;

  localparam logic [7:0] LEN_RUN   = 8'd1;
  localparam logic [7:0] LEN_FWORD = 8'd4;
  localparam logic [7:0] LEN_PWORD = 8'd1;
  localparam logic [7:0] LEN_MODE  = 8'd1;
  localparam logic [7:0] LEN_DUTY  = 8'd2;

  localparam logic [31:0] MODE_MAX = 32'd5;
  localparam logic [31:0] DUTY_MAX = 32'd1000;

  localparam logic [26:0] FWORD_RST = 27'd320000;
  localparam logic [9:0]  DUTY_RST  = 10'd500;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_CMD,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } state_t;

  // Required payload length per opcode; zero marks an unknown opcode.
  function automatic logic [7:0] req_len(input logic [7:0] cmd);
    case (cmd)
      CMD_RUN:   return LEN_RUN;
      CMD_FWORD: return LEN_FWORD;
      CMD_PWORD: return LEN_PWORD;
      CMD_MODE:  return LEN_MODE;
      CMD_DUTY:  return LEN_DUTY;
      default:   return 8'd0;
    endcase
  endfunction

  function automatic logic in_range(input logic [7:0] cmd, input logic [31:0] payload);
    case (cmd)
      CMD_FWORD: return payload[31:27] == 5'd0;
      CMD_MODE:  return payload <= MODE_MAX;
      CMD_DUTY:  return payload <= DUTY_MAX;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dds_cmd_timeout.sv
// Inter-byte stall detector: counts idle cycles while a frame is open and pulses
// o_expire on the cycle the budget runs out. A byte on the same cycle always wins.
module dds_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  assign o_expire = i_en && !i_clr && (cnt == TERM);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (!i_en || i_clr || o_expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dds_cmd_parser.sv
// Frames, checksums and range-checks DDS configuration commands from the UDP byte
// stream; accepted commands update one held output and pulse its strobe.
module dds_cmd_parser
  import dds_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_vld,
  output logic        o_run,
  output logic        o_run_vld,
  output logic [26:0] o_fword,
  output logic        o_fword_vld,
  output logic [7:0]  o_pword,
  output logic        o_pword_vld,
  output logic [2:0]  o_mode,
  output logic        o_mode_vld,
  output logic [9:0]  o_duty,
  output logic        o_duty_vld,
  output logic        o_frame_ok,
  output logic        o_frame_err
);

  state_t      state;
  logic [7:0]  cmd;
  logic [7:0]  csum;
  logic [31:0] payload;
  logic [2:0]  cnt;
  logic        tmo_expire;

  dds_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (state != ST_IDLE),
    .i_clr    (i_byte_vld),
    .o_expire (tmo_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cmd         <= '0;
      csum        <= '0;
      payload     <= '0;
      cnt         <= '0;
      o_run       <= 1'b1;
      o_fword     <= FWORD_RST;
      o_pword     <= '0;
      o_mode      <= '0;
      o_duty      <= DUTY_RST;
      o_run_vld   <= 1'b0;
      o_fword_vld <= 1'b0;
      o_pword_vld <= 1'b0;
      o_mode_vld  <= 1'b0;
      o_duty_vld  <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_run_vld   <= 1'b0;
      o_fword_vld <= 1'b0;
      o_pword_vld <= 1'b0;
      o_mode_vld  <= 1'b0;
      o_duty_vld  <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;

      if (i_byte_vld) begin
        unique case (state)
          ST_IDLE: begin
            if (i_byte == HDR0) state <= ST_HDR2;
          end
          ST_HDR2: begin
            // A repeated 0x55 may be the real start of the header, so keep waiting for 0xAA.
            if (i_byte == HDR1)      state <= ST_CMD;
            else if (i_byte != HDR0) state <= ST_IDLE;
          end
          ST_CMD: begin
            cmd   <= i_byte;
            csum  <= i_byte;
            state <= ST_LEN;
          end
          ST_LEN: begin
            if (req_len(cmd) == 8'd0 || i_byte != req_len(cmd)) begin
              o_frame_err <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              cnt     <= i_byte[2:0];
              csum    <= csum + i_byte;
              payload <= '0;
              state   <= ST_DATA;
            end
          end
          ST_DATA: begin
            payload <= {payload[23:0], i_byte};
            csum    <= csum + i_byte;
            cnt     <= cnt - 3'd1;
            if (cnt == 3'd1) state <= ST_CSUM;
          end
          ST_CSUM: begin
            state <= ST_IDLE;
            if (i_byte != csum || !in_range(cmd, payload)) begin
              o_frame_err <= 1'b1;
            end else begin
              o_frame_ok <= 1'b1;
              case (cmd)
                CMD_RUN: begin
                  o_run     <= payload[0];
                  o_run_vld <= 1'b1;
                end
                CMD_FWORD: begin
                  o_fword     <= payload[26:0];
                  o_fword_vld <= 1'b1;
                end
                CMD_PWORD: begin
                  o_pword     <= payload[7:0];
                  o_pword_vld <= 1'b1;
                end
                CMD_MODE: begin
                  o_mode     <= payload[2:0];
                  o_mode_vld <= 1'b1;
                end
                CMD_DUTY: begin
                  o_duty     <= payload[9:0];
                  o_duty_vld <= 1'b1;
                end
                default: begin
                  o_frame_ok  <= 1'b0;
                  o_frame_err <= 1'b1;
                end
              endcase
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (tmo_expire) begin
        o_frame_err <= 1'b1;
        state       <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Scoreboard bench for dds_cmd_parser: frames are built and judged by a byte-level
// reference model, expected pulses are queued, and a negedge monitor checks them.
module tb_dds_cmd_parser;

  localparam int T = 1000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_byte_vld = 1'b0;
  logic        o_run, o_run_vld, o_fword_vld, o_pword_vld, o_mode_vld, o_duty_vld;
  logic [26:0] o_fword;
  logic [7:0]  o_pword;
  logic [2:0]  o_mode;
  logic [9:0]  o_duty;
  logic        o_frame_ok, o_frame_err;

  dds_cmd_parser #(.TIMEOUT_CYC(T)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_byte      (i_byte),
    .i_byte_vld  (i_byte_vld),
    .o_run       (o_run),
    .o_run_vld   (o_run_vld),
    .o_fword     (o_fword),
    .o_fword_vld (o_fword_vld),
    .o_pword     (o_pword),
    .o_pword_vld (o_pword_vld),
    .o_mode      (o_mode),
    .o_mode_vld  (o_mode_vld),
    .o_duty      (o_duty),
    .o_duty_vld  (o_duty_vld),
    .o_frame_ok  (o_frame_ok),
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the currently held output values.
  bit m_run;
  int m_fword, m_pword, m_mode, m_duty;

  task automatic model_reset();
    m_run = 1'b1; m_fword = 320000; m_pword = 0; m_mode = 0; m_duty = 500;
  endtask

  typedef struct {
    bit is_err;
    int tgt;
    int due;
    bit run;
    int fword, pword, mode, duty;
  } exp_t;

  exp_t sb[$];

  task automatic push(input bit is_err, input int tgt, input int due);
    exp_t e;
    e.is_err = is_err; e.tgt = tgt; e.due = due;
    e.run = m_run; e.fword = m_fword; e.pword = m_pword; e.mode = m_mode; e.duty = m_duty;
    sb.push_back(e);
  endtask

  function automatic int req_len_of(input int cmd);
    case (cmd)
      1: return 1;
      2: return 4;
      3: return 1;
      4: return 1;
      5: return 2;
      default: return 0;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input int b);
    i_byte = b[7:0];
    i_byte_vld = 1'b1;
    @(posedge i_clk);
    #1;
    i_byte_vld = 1'b0;
  endtask

  // csum_in: >=0 explicit byte, -1 correct checksum, -2 corrupted checksum.
  // long_gap_pos: index of the byte preceded by T-1 idle cycles (-1 for none).
  task automatic send_frame(input int cmd, input int len, input longint val,
                            input int csum_in, input int long_gap_pos);
    int bytes[$];
    int req, sum, exp_cs, cs, b;
    bit len_ok, rng_ok;
    req = req_len_of(cmd);
    len_ok = (req != 0) && (len == req);
    bytes = {8'h55, 8'hAA, cmd, len};
    sum = cmd + len;
    cs = 0;
    exp_cs = 0;
    if (len_ok) begin
      for (int i = 0; i < len; i++) begin
        b = int'((val >> (8 * (len - 1 - i))) & 64'hFF);
        bytes.push_back(b);
        sum += b;
      end
      exp_cs = sum % 256;
      if (csum_in == -1)      cs = exp_cs;
      else if (csum_in == -2) cs = (exp_cs + $urandom_range(1, 255)) % 256;
      else                    cs = csum_in;
      bytes.push_back(cs);
    end
    foreach (bytes[i]) begin
      if (i == long_gap_pos) idle(T - 1);
      else if (i > 0)        idle($urandom_range(0, 2));
      send_byte(bytes[i]);
    end
    if (!len_ok) begin
      push(1'b1, 0, cyc);
    end else begin
      case (cmd)
        2: rng_ok = val < 64'd134217728;
        4: rng_ok = val <= 5;
        5: rng_ok = val <= 1000;
        default: rng_ok = 1'b1;
      endcase
      if (cs != exp_cs || !rng_ok) begin
        push(1'b1, 0, cyc);
      end else begin
        case (cmd)
          1: m_run = val[0];
          2: m_fword = int'(val);
          3: m_pword = int'(val);
          4: m_mode = int'(val);
          default: m_duty = int'(val);
        endcase
        push(1'b0, cmd - 1, cyc);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_run"}, o_run, 1);
    check({tag, "_fword"}, o_fword, 320000);
    check({tag, "_pword"}, o_pword, 0);
    check({tag, "_mode"}, o_mode, 0);
    check({tag, "_duty"}, o_duty, 500);
    check({tag, "_pulses"},
          {o_run_vld, o_fword_vld, o_pword_vld, o_mode_vld, o_duty_vld, o_frame_ok, o_frame_err}, 0);
  endtask

  // Monitor: every strobe the DUT shows must match the oldest expected event.
  exp_t       mon_e;
  logic [4:0] mon_vv;
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      mon_vv = {o_run_vld, o_fword_vld, o_pword_vld, o_mode_vld, o_duty_vld};
      if (mon_vv != 5'd0 || o_frame_ok || o_frame_err) begin
        check("ok_err_exclusive", o_frame_ok & o_frame_err, 0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got vld=%b ok=%b err=%b, expected no pulse (t=%0t)",
                   mon_vv, o_frame_ok, o_frame_err, $time);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_err", o_frame_err, mon_e.is_err);
          check("pulse_ok", o_frame_ok, !mon_e.is_err);
          check("pulse_cycle", cyc, mon_e.due);
          check("vld_vector", mon_vv, mon_e.is_err ? 5'd0 : (5'b10000 >> mon_e.tgt));
          check("held_run", o_run, mon_e.run);
          check("held_fword", o_fword, mon_e.fword);
          check("held_pword", o_pword, mon_e.pword);
          check("held_mode", o_mode, mon_e.mode);
          check("held_duty", o_duty, mon_e.duty);
        end
      end
    end
  end

  initial begin
    int r, cmd, len, cs, junk;
    longint v;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_values("reset");
    i_rst_n = 1'b1;
    idle(2);

    // Directed frames from the command set.
    send_frame(2, 4, 64'h2710, 'h3D, -1);
    send_frame(5, 2, 1001, 'hF3, -1);
    send_frame(5, 2, 250, 'h01, -1);
    send_frame(4, 1, 2, 'h00, -1);
    send_frame(4, 1, 2, 'h07, -1);
    send_byte('h55);
    send_frame(3, 1, 'h80, 'h84, -1);
    send_byte('h55);
    send_byte('h12);
    idle(3);

    // Stall after the opcode: error exactly T cycles after the last byte.
    send_byte('h55);
    send_byte('hAA);
    send_byte('h01);
    push(1'b1, 0, cyc + T);
    idle(T + 3);
    send_frame(1, 1, 0, 'h02, -1);

    // Boundaries: T-1 idle cycles inside a frame, limit values, unknown opcode, bad LEN.
    send_frame(4, 1, 5, -1, 3);
    send_frame(4, 1, 6, -1, -1);
    send_frame(5, 2, 1000, -1, 5);
    send_frame(2, 4, 64'h7FFFFFF, -1, -1);
    send_frame(2, 4, 64'h8000000, -1, -1);
    send_frame(9, 1, 0, -1, -1);
    send_frame(5, 1, 0, -1, -1);
    send_frame(3, 1, 'h55, -1, -1);
    idle(0);
    send_frame(3, 1, 'h5A, -1, -1);

    // Reset in the middle of a payload.
    send_frame(2, 4, 64'd777, -1, -1);
    idle(3);
    send_byte('h55);
    send_byte('hAA);
    send_byte('h02);
    send_byte('h04);
    send_byte('h00);
    send_byte('h12);
    i_rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    idle(2);
    check_reset_values("midreset_hold");
    i_rst_n = 1'b1;
    idle(1);
    send_frame(2, 4, 64'd12345, -1, -1);

    // Randomized frames.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          junk = $urandom_range(0, 255);
          if (junk == 'h55) junk = 'h12;
          send_byte(junk);
        end
      end
      r = $urandom_range(0, 99);
      if (r < 90) cmd = r % 5 + 1;
      else        cmd = (r % 2 == 1) ? 0 : $urandom_range(6, 255);
      len = req_len_of(cmd);
      if (len == 0)                        len = $urandom_range(0, 8);
      else if ($urandom_range(0, 9) == 0)  len = (len == 1) ? 2 : len - 1;
      case (cmd)
        1: v = $urandom_range(0, 255);
        2: v = ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom & 32'h07FF_FFFF);
        3: v = $urandom_range(0, 255);
        4: v = $urandom_range(0, 7);
        default: v = $urandom_range(0, 1023);
      endcase
      cs = ($urandom_range(0, 7) == 0) ? -2 : -1;
      send_frame(cmd, len, v, cs, -1);
      idle($urandom_range(0, 2));
    end

    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
